regfile_wb_arbiter: RTL

- Shares the register bank's single write port between two writeback sources: ALU result path (requester 0) and load/store unit (requester 1).
- Round-robin arbitration; one registered stage drives the bank's write_en/write_index/write inputs.
- Per-register pending-write scoreboard: issue stage reserves a destination register, commit releases it; busy vector feeds the decode hazard check.

---
 rtl/regfile_wb_arbiter.sv | 134 +++++++++++++
 1 files changed

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register bank's single write port between the ALU and LSU,
// plus a per-register pending-write scoreboard that drives the decode busy vector.
module regfile_wb_arbiter #(
  parameter int NUM_REGS = 16,
  parameter int IDX_W    = 4,
  parameter int DATA_W   = 32,
  parameter int CNT_W    = 2
) (
  input  logic              clk,
  input  logic              i_rst_sync_n,
  input  logic              i_alu_valid,
  output logic              o_alu_ready,
  input  logic [IDX_W-1:0]  i_alu_index,
  input  logic [DATA_W-1:0] i_alu_data,
  input  logic              i_lsu_valid,
  output logic              o_lsu_ready,
  input  logic [IDX_W-1:0]  i_lsu_index,
  input  logic [DATA_W-1:0] i_lsu_data,
  input  logic              i_reserve_en,
  input  logic [IDX_W-1:0]  i_reserve_index,
  output logic              o_rf_write_en,
  output logic [IDX_W-1:0]  o_rf_write_index,
  output logic [DATA_W-1:0] o_rf_write,
  output logic [NUM_REGS-1:0] o_busy,
  output logic              o_sb_error
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic                w_grant_alu;
  logic                w_grant_lsu;
  logic                w_xfer;
  logic [IDX_W-1:0]    w_sel_index;
  logic [DATA_W-1:0]   w_sel_data;
  logic                r_last_grant;  // 0 = ALU, 1 = LSU
  logic                r_wr_en;
  logic [IDX_W-1:0]    r_wr_index;
  logic [DATA_W-1:0]   r_wr_data;
  logic                r_sb_error;
  logic [NUM_REGS-1:0] w_busy;
  logic [NUM_REGS-1:0] w_err;

  always_comb begin
    w_grant_alu = 1'b0;
    w_grant_lsu = 1'b0;
    if (i_rst_sync_n) begin
      if (i_alu_valid && i_lsu_valid) begin
        w_grant_alu = r_last_grant;
        w_grant_lsu = !r_last_grant;
      end else begin
        w_grant_alu = i_alu_valid;
        w_grant_lsu = i_lsu_valid;
      end
    end
  end

  assign w_xfer      = w_grant_alu | w_grant_lsu;
  assign w_sel_index = w_grant_lsu ? i_lsu_index : i_alu_index;
  assign w_sel_data  = w_grant_lsu ? i_lsu_data  : i_alu_data;

  always_ff @(posedge clk) begin
    if (!i_rst_sync_n) begin
      r_wr_en      <= 1'b0;
      r_wr_index   <= '0;
      r_wr_data    <= '0;
      r_last_grant <= 1'b1;
    end else if (w_xfer) begin
      // Writes to r0 still handshake but never reach the bank or the scoreboard.
      r_wr_en      <= (w_sel_index != '0);
      r_wr_index   <= w_sel_index;
      r_wr_data    <= w_sel_data;
      r_last_grant <= w_grant_lsu;
    end else begin
      r_wr_en <= 1'b0;
    end
  end

  assign w_busy[0] = 1'b0;
  assign w_err[0]  = 1'b0;

  genvar gi;
  generate
    for (gi = 1; gi < NUM_REGS; gi++) begin : g_sb
      logic             w_inc;
      logic             w_dec;
      logic             w_err_bit;
      logic [CNT_W-1:0] w_cnt_next;
      logic [CNT_W-1:0] r_cnt;
      logic             r_busy;

      assign w_inc = i_reserve_en && (i_reserve_index == IDX_W'(gi));
      assign w_dec = r_wr_en && (r_wr_index == IDX_W'(gi));

      always_comb begin
        w_cnt_next = r_cnt;
        w_err_bit  = 1'b0;
        if (w_inc && !w_dec) begin
          if (r_cnt == CNT_MAX) w_err_bit = 1'b1;
          else                  w_cnt_next = r_cnt + 1'b1;
        end else if (w_dec && !w_inc) begin
          if (r_cnt == '0) w_err_bit = 1'b1;
          else             w_cnt_next = r_cnt - 1'b1;
        end
      end

      always_ff @(posedge clk) begin
        if (!i_rst_sync_n) begin
          r_cnt  <= '0;
          r_busy <= 1'b0;
        end else begin
          r_cnt  <= w_cnt_next;
          r_busy <= (w_cnt_next != '0);
        end
      end

      assign w_busy[gi] = r_busy;
      assign w_err[gi]  = w_err_bit;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!i_rst_sync_n) r_sb_error <= 1'b0;
    else if (|w_err)   r_sb_error <= 1'b1;
  end

  assign o_alu_ready      = w_grant_alu;
  assign o_lsu_ready      = w_grant_lsu;
  assign o_rf_write_en    = r_wr_en;
  assign o_rf_write_index = r_wr_index;
  assign o_rf_write       = r_wr_data;
  assign o_busy           = w_busy;
  assign o_sb_error       = r_sb_error;

endmodule
